// File: rtl/pll_supervisor_pkg.sv
// Shared types and constants for the PLL supervisor: state encoding, output widths,
// and the counter-width helper.
package pll_supervisor_pkg;

  localparam int unsigned RETRY_W = 4;
  localparam int unsigned LOSS_W  = 8;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_PLL_RST   = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABLE    = 3'd2;
  localparam logic [2:0] ST_RELEASE   = 3'd3;
  localparam logic [2:0] ST_RUN       = 3'd4;
  localparam logic [2:0] ST_FAIL      = 3'd5;

  // Bits needed to count 0 .. (largest cycle parameter - 1), minimum one bit.
  function automatic int unsigned cnt_width(input int unsigned rst_cycles,
                                            input int unsigned timeout_cycles,
                                            input int unsigned stable_cycles,
                                            input int unsigned gap_cycles);
    int unsigned m;
    m = rst_cycles;
    if (timeout_cycles > m) m = timeout_cycles;
    if (stable_cycles > m)  m = stable_cycles;
    if (gap_cycles > m)     m = gap_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; resets to zero.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/pll_supervisor.sv
// PLL reset/lock supervisor with retry, stable-lock qualification and sequenced channel release.
// Optional lock-loss counter output enabled by PLL_SUPERVISOR_LOSS_COUNT_EN.
module pll_supervisor
  import pll_supervisor_pkg::*;
#(
  parameter int unsigned CHANNELS            = 2,
  parameter int unsigned PLL_RESET_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned RELEASE_GAP_CYCLES  = 8,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pll_lock_i,
  output logic                pll_reset_o,
  output logic [CHANNELS-1:0] rst_n_o,
  output logic                locked_o,
  output logic                fail_o,
  output logic [RETRY_W-1:0]  retry_count_o
`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
  ,
  output logic [LOSS_W-1:0]   loss_count_o
`endif
);

  localparam int unsigned CNT_W = cnt_width(PLL_RESET_CYCLES, LOCK_TIMEOUT_CYCLES,
                                            LOCK_STABLE_CYCLES, RELEASE_GAP_CYCLES);
  localparam int unsigned IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(PLL_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST    = CNT_W'(RELEASE_GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0]   CH_LAST     = IDX_W'(CHANNELS - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  logic lock_s;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock_i),
    .q     (lock_s)
  );

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 pll_reset_q, pll_reset_d;
  logic [CHANNELS-1:0]  rst_n_q, rst_n_d;
  logic                 locked_q, locked_d;
  logic                 fail_q, fail_d;
  logic                 lost;
`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
  logic [LOSS_W-1:0]    loss_q, loss_d;
`endif

  // Next-state and next-output logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    lost    = 1'b0;

    case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TO_LAST) begin
          if (retry_q == RETRY_MAX) begin
            state_d = ST_FAIL;
          end else begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = ST_PLL_RST;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RELEASE;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (!lock_s) begin
          lost = 1'b1;
        end else if (idx_q == CH_LAST) begin
          state_d = ST_RUN;
        end else if (cnt_q == GAP_LAST) begin
          idx_d = idx_q + IDX_W'(1);
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) lost = 1'b1;
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_PLL_RST;
      end
    endcase

    // Lock loss after qualification: full recovery with a fresh retry budget.
    if (lost) begin
      state_d = ST_PLL_RST;
      retry_d = '0;
    end

    if (state_d != state_q) cnt_d = '0;

    pll_reset_d = (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
    locked_d    = (state_d == ST_RUN);
    fail_d      = (state_d == ST_FAIL);

    rst_n_d = '0;
    if ((state_d == ST_RELEASE) || (state_d == ST_RUN)) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        rst_n_d[i] = (IDX_W'(i) <= idx_d);
      end
    end

`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
    loss_d = loss_q;
    if (lost && (loss_q != {LOSS_W{1'b1}})) loss_d = loss_q + LOSS_W'(1);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PLL_RST;
      cnt_q       <= '0;
      idx_q       <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      rst_n_q     <= '0;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      rst_n_q     <= rst_n_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
    end
  end

`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) loss_q <= '0;
    else        loss_q <= loss_d;
  end

  assign loss_count_o = loss_q;
`endif

  assign pll_reset_o   = pll_reset_q;
  assign rst_n_o       = rst_n_q;
  assign locked_o      = locked_q;
  assign fail_o        = fail_q;
  assign retry_count_o = retry_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// Directed self-checking bench for pll_supervisor with shortened timing parameters.
module tb_pll_supervisor;

  logic       clk;
  logic       rst_n;
  logic       pll_lock;
  logic       pll_reset_o;
  logic [2:0] rst_n_o;
  logic       locked_o;
  logic       fail_o;
  logic [3:0] retry_count_o;
`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
  logic [7:0] loss_count_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  pll_supervisor #(
    .CHANNELS            (3),
    .PLL_RESET_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (32),
    .LOCK_STABLE_CYCLES  (8),
    .RELEASE_GAP_CYCLES  (3),
    .MAX_RETRIES         (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pll_lock_i    (pll_lock),
    .pll_reset_o   (pll_reset_o),
    .rst_n_o       (rst_n_o),
    .locked_o      (locked_o),
    .fail_o        (fail_o),
    .retry_count_o (retry_count_o)
`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
    ,
    .loss_count_o  (loss_count_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset is released on a falling edge; the next rising edge is cycle 1.
  task automatic do_reset();
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (pll_reset_o !== 1'b1)   begin n_bad++; $display("FAIL reset pll_reset_o got %0b want 1", pll_reset_o); end
    n_cmp++; if (rst_n_o !== 3'b000)     begin n_bad++; $display("FAIL reset rst_n_o got %b want 000", rst_n_o); end
    n_cmp++; if (locked_o !== 1'b0)      begin n_bad++; $display("FAIL reset locked_o got %0b want 0", locked_o); end
    n_cmp++; if (fail_o !== 1'b0)        begin n_bad++; $display("FAIL reset fail_o got %0b want 0", fail_o); end
    n_cmp++; if (retry_count_o !== 4'd0) begin n_bad++; $display("FAIL reset retry got %0d want 0", retry_count_o); end
`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
    n_cmp++; if (loss_count_o !== 8'd0)  begin n_bad++; $display("FAIL reset loss_count got %0d want 0", loss_count_o); end
`endif
  endtask

  // Lock sampled from cycle 10: STABLE from 12, bits at 20/23/26, RUN at 27.
  task automatic test_bring_up();
    logic       exp_pr;
    logic [2:0] exp_rst;
    logic       exp_lk;
    do_reset();
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 9) pll_lock = 1'b1;
      exp_pr  = (k < 4);
      exp_rst = (k < 20) ? 3'b000 : (k < 23) ? 3'b001 : (k < 26) ? 3'b011 : 3'b111;
      exp_lk  = (k >= 27);
      n_cmp++; if (pll_reset_o !== exp_pr) begin n_bad++; $display("FAIL bring_up c%0d pll_reset_o got %0b want %0b", k, pll_reset_o, exp_pr); end
      n_cmp++; if (rst_n_o !== exp_rst)    begin n_bad++; $display("FAIL bring_up c%0d rst_n_o got %b want %b", k, rst_n_o, exp_rst); end
      n_cmp++; if (locked_o !== exp_lk)    begin n_bad++; $display("FAIL bring_up c%0d locked_o got %0b want %0b", k, locked_o, exp_lk); end
    end
    n_cmp++; if (retry_count_o !== 4'd0) begin n_bad++; $display("FAIL bring_up retry got %0d want 0", retry_count_o); end
    n_cmp++; if (fail_o !== 1'b0)        begin n_bad++; $display("FAIL bring_up fail_o got %0b want 0", fail_o); end
  endtask

  // One low sample at cycle 15 sends STABLE back to WAIT_LOCK at 17; restart at 18, release at 26.
  task automatic test_lock_glitch();
    do_reset();
    for (int k = 1; k <= 29; k++) begin
      tick();
      if (k == 9)  pll_lock = 1'b1;
      if (k == 14) pll_lock = 1'b0;
      if (k == 15) pll_lock = 1'b1;
      if (k == 17) begin
        n_cmp++; if (pll_reset_o !== 1'b0) begin n_bad++; $display("FAIL glitch c17 pll_reset_o got %0b want 0", pll_reset_o); end
      end
      if (k == 20) begin
        n_cmp++; if (rst_n_o !== 3'b000) begin n_bad++; $display("FAIL glitch c20 rst_n_o got %b want 000", rst_n_o); end
      end
      if (k == 25) begin
        n_cmp++; if (rst_n_o !== 3'b000) begin n_bad++; $display("FAIL glitch c25 rst_n_o got %b want 000", rst_n_o); end
      end
      if (k == 26) begin
        n_cmp++; if (rst_n_o !== 3'b001) begin n_bad++; $display("FAIL glitch c26 rst_n_o got %b want 001", rst_n_o); end
      end
      if (k == 29) begin
        n_cmp++; if (rst_n_o !== 3'b011)     begin n_bad++; $display("FAIL glitch c29 rst_n_o got %b want 011", rst_n_o); end
        n_cmp++; if (retry_count_o !== 4'd0) begin n_bad++; $display("FAIL glitch retry got %0d want 0", retry_count_o); end
      end
    end
  endtask

  // Loss sampled at 31 reaches the FSM at 33; recovery re-releases at 46/49/52, RUN at 53.
  task automatic test_lock_loss();
    do_reset();
    for (int k = 1; k <= 53; k++) begin
      tick();
      if (k == 9)  pll_lock = 1'b1;
      if (k == 30) pll_lock = 1'b0;
      if (k == 33) pll_lock = 1'b1;
      case (k)
        32: begin
          n_cmp++; if (rst_n_o !== 3'b111) begin n_bad++; $display("FAIL loss c32 rst_n_o got %b want 111", rst_n_o); end
          n_cmp++; if (locked_o !== 1'b1)  begin n_bad++; $display("FAIL loss c32 locked_o got %0b want 1", locked_o); end
        end
        33: begin
          n_cmp++; if (rst_n_o !== 3'b000)   begin n_bad++; $display("FAIL loss c33 rst_n_o got %b want 000", rst_n_o); end
          n_cmp++; if (locked_o !== 1'b0)    begin n_bad++; $display("FAIL loss c33 locked_o got %0b want 0", locked_o); end
          n_cmp++; if (pll_reset_o !== 1'b1) begin n_bad++; $display("FAIL loss c33 pll_reset_o got %0b want 1", pll_reset_o); end
        end
        36: begin
          n_cmp++; if (pll_reset_o !== 1'b1) begin n_bad++; $display("FAIL loss c36 pll_reset_o got %0b want 1", pll_reset_o); end
        end
        37: begin
          n_cmp++; if (pll_reset_o !== 1'b0) begin n_bad++; $display("FAIL loss c37 pll_reset_o got %0b want 0", pll_reset_o); end
        end
        45: begin
          n_cmp++; if (rst_n_o !== 3'b000) begin n_bad++; $display("FAIL loss c45 rst_n_o got %b want 000", rst_n_o); end
        end
        46: begin
          n_cmp++; if (rst_n_o !== 3'b001) begin n_bad++; $display("FAIL loss c46 rst_n_o got %b want 001", rst_n_o); end
        end
        49: begin
          n_cmp++; if (rst_n_o !== 3'b011) begin n_bad++; $display("FAIL loss c49 rst_n_o got %b want 011", rst_n_o); end
        end
        52: begin
          n_cmp++; if (rst_n_o !== 3'b111) begin n_bad++; $display("FAIL loss c52 rst_n_o got %b want 111", rst_n_o); end
          n_cmp++; if (locked_o !== 1'b0)  begin n_bad++; $display("FAIL loss c52 locked_o got %0b want 0", locked_o); end
        end
        53: begin
          n_cmp++; if (locked_o !== 1'b1)      begin n_bad++; $display("FAIL loss c53 locked_o got %0b want 1", locked_o); end
          n_cmp++; if (retry_count_o !== 4'd0) begin n_bad++; $display("FAIL loss retry got %0d want 0", retry_count_o); end
`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
          n_cmp++; if (loss_count_o !== 8'd1)  begin n_bad++; $display("FAIL loss loss_count got %0d want 1", loss_count_o); end
`endif
        end
        default: ;
      endcase
    end
  endtask

  // Reset asserted between clock edges while rst_n_o=011 must clear outputs without an edge.
  task automatic test_async_reset();
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 9) pll_lock = 1'b1;
    end
    n_cmp++; if (rst_n_o !== 3'b011) begin n_bad++; $display("FAIL async pre rst_n_o got %b want 011", rst_n_o); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (pll_reset_o !== 1'b1) begin n_bad++; $display("FAIL async pll_reset_o got %0b want 1", pll_reset_o); end
    n_cmp++; if (rst_n_o !== 3'b000)   begin n_bad++; $display("FAIL async rst_n_o got %b want 000", rst_n_o); end
    n_cmp++; if (locked_o !== 1'b0)    begin n_bad++; $display("FAIL async locked_o got %0b want 0", locked_o); end
  endtask

  // Lock reaching the FSM exactly on the first timeout cycle (36) counts as lock.
  task automatic test_timeout_lock();
    do_reset();
    for (int k = 1; k <= 44; k++) begin
      tick();
      if (k == 33) pll_lock = 1'b1;
      if (k == 36 || k == 37) begin
        n_cmp++; if (pll_reset_o !== 1'b0)   begin n_bad++; $display("FAIL to_lock c%0d pll_reset_o got %0b want 0", k, pll_reset_o); end
        n_cmp++; if (retry_count_o !== 4'd0) begin n_bad++; $display("FAIL to_lock c%0d retry got %0d want 0", k, retry_count_o); end
      end
      if (k == 43) begin
        n_cmp++; if (rst_n_o !== 3'b000) begin n_bad++; $display("FAIL to_lock c43 rst_n_o got %b want 000", rst_n_o); end
      end
      if (k == 44) begin
        n_cmp++; if (rst_n_o !== 3'b001) begin n_bad++; $display("FAIL to_lock c44 rst_n_o got %b want 001", rst_n_o); end
      end
    end
  endtask

  // No lock: retries at 36 and 72, FAIL at 108, terminal even if lock appears later.
  task automatic test_retry_fail();
    do_reset();
    for (int k = 1; k <= 130; k++) begin
      tick();
      if (k == 110) pll_lock = 1'b1;
      case (k)
        35: begin
          n_cmp++; if (pll_reset_o !== 1'b0)   begin n_bad++; $display("FAIL retry c35 pll_reset_o got %0b want 0", pll_reset_o); end
          n_cmp++; if (retry_count_o !== 4'd0) begin n_bad++; $display("FAIL retry c35 retry got %0d want 0", retry_count_o); end
        end
        36: begin
          n_cmp++; if (pll_reset_o !== 1'b1)   begin n_bad++; $display("FAIL retry c36 pll_reset_o got %0b want 1", pll_reset_o); end
          n_cmp++; if (retry_count_o !== 4'd1) begin n_bad++; $display("FAIL retry c36 retry got %0d want 1", retry_count_o); end
        end
        39: begin
          n_cmp++; if (pll_reset_o !== 1'b1) begin n_bad++; $display("FAIL retry c39 pll_reset_o got %0b want 1", pll_reset_o); end
        end
        40: begin
          n_cmp++; if (pll_reset_o !== 1'b0) begin n_bad++; $display("FAIL retry c40 pll_reset_o got %0b want 0", pll_reset_o); end
        end
        71: begin
          n_cmp++; if (retry_count_o !== 4'd1) begin n_bad++; $display("FAIL retry c71 retry got %0d want 1", retry_count_o); end
        end
        72: begin
          n_cmp++; if (retry_count_o !== 4'd2) begin n_bad++; $display("FAIL retry c72 retry got %0d want 2", retry_count_o); end
          n_cmp++; if (pll_reset_o !== 1'b1)   begin n_bad++; $display("FAIL retry c72 pll_reset_o got %0b want 1", pll_reset_o); end
        end
        76: begin
          n_cmp++; if (pll_reset_o !== 1'b0) begin n_bad++; $display("FAIL retry c76 pll_reset_o got %0b want 0", pll_reset_o); end
        end
        107: begin
          n_cmp++; if (fail_o !== 1'b0) begin n_bad++; $display("FAIL retry c107 fail_o got %0b want 0", fail_o); end
        end
        108, 130: begin
          n_cmp++; if (fail_o !== 1'b1)        begin n_bad++; $display("FAIL retry c%0d fail_o got %0b want 1", k, fail_o); end
          n_cmp++; if (pll_reset_o !== 1'b1)   begin n_bad++; $display("FAIL retry c%0d pll_reset_o got %0b want 1", k, pll_reset_o); end
          n_cmp++; if (rst_n_o !== 3'b000)     begin n_bad++; $display("FAIL retry c%0d rst_n_o got %b want 000", k, rst_n_o); end
          n_cmp++; if (retry_count_o !== 4'd2) begin n_bad++; $display("FAIL retry c%0d retry got %0d want 2", k, retry_count_o); end
          n_cmp++; if (locked_o !== 1'b0)      begin n_bad++; $display("FAIL retry c%0d locked_o got %0b want 0", k, locked_o); end
        end
        default: ;
      endcase
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (fail_o !== 1'b0)        begin n_bad++; $display("FAIL retry reset fail_o got %0b want 0", fail_o); end
    n_cmp++; if (retry_count_o !== 4'd0) begin n_bad++; $display("FAIL retry reset retry got %0d want 0", retry_count_o); end
  endtask

  initial begin
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    test_reset();
    test_bring_up();
    test_lock_glitch();
    test_lock_loss();
    test_async_reset();
    test_timeout_lock();
    test_retry_fail();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
